// File: rtl/pcie_tx_arb_pkg.sv
// Shared types and encodings for the PCIe transmit arbiter: FSM states,
// source identifiers and the grant_id status encodings.
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam logic SRC_PIO = 1'b0;
    localparam logic SRC_INJ = 1'b1;

    localparam logic [1:0] GID_IDLE = 2'd0;
    localparam logic [1:0] GID_SRC0 = 2'd1;
    localparam logic [1:0] GID_SRC1 = 2'd2;

    function automatic logic [1:0] grant_id_of(input arb_state_t st);
        logic [1:0] gid_s;
        case (st)
            GRANT0:  gid_s = GID_SRC0;
            GRANT1:  gid_s = GID_SRC1;
            default: gid_s = GID_IDLE;
        endcase
        return gid_s;
    endfunction

endpackage

// File: rtl/pcie_tx_arbiter.sv
// Whole-TLP round-robin arbiter sharing the PCIe core TX AXI4-Stream port
// between the PIO completion engine (source 0) and the inject path (source 1).
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst,
    input  logic                    s0_req,
    output logic                    s0_ack,
    input  logic                    s0_tvalid,
    input  logic                    s0_tlast,
    output logic                    s0_tready,
    input  logic [C_DATA_WIDTH-1:0] s0_tdata,
    input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
    input  logic [3:0]              s0_tuser,
    input  logic                    s1_tvalid,
    input  logic                    s1_tlast,
    output logic                    s1_tready,
    input  logic [C_DATA_WIDTH-1:0] s1_tdata,
    input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
    input  logic [3:0]              s1_tuser,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic [KEEP_WIDTH-1:0]   m_tkeep,
    output logic [3:0]              m_tuser,
    output logic [1:0]              grant_id,
    output logic [CNT_WIDTH-1:0]    pkt_cnt0,
    output logic [CNT_WIDTH-1:0]    pkt_cnt1
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    arb_state_t             state_r;
    arb_state_t             state_s;
    logic                   last_r;
    logic [CNT_WIDTH-1:0]   cnt0_r;
    logic [CNT_WIDTH-1:0]   cnt1_r;
    logic                   eop_s;

    // Next-state selection and the zero-latency datapath mux.
    always_comb begin
        state_s   = state_r;
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tuser   = 4'd0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_r)
            IDLE: begin
                // On a tie the source not served last wins.
                if (s0_req && s1_tvalid) begin
                    state_s = (last_r == SRC_PIO) ? GRANT1 : GRANT0;
                end else if (s0_req) begin
                    state_s = GRANT0;
                end else if (s1_tvalid) begin
                    state_s = GRANT1;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT0: begin
                m_tvalid  = s0_tvalid;
                m_tlast   = s0_tlast;
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tuser   = s0_tuser;
                s0_tready = m_tready;
                if (s0_tvalid && m_tready && s0_tlast) begin
                    state_s = IDLE;
                end else begin
                    state_s = GRANT0;
                end
            end
            GRANT1: begin
                m_tvalid  = s1_tvalid;
                m_tlast   = s1_tlast;
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tuser   = s1_tuser;
                s1_tready = m_tready;
                if (s1_tvalid && m_tready && s1_tlast) begin
                    state_s = IDLE;
                end else begin
                    state_s = GRANT1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign eop_s = m_tvalid & m_tready & m_tlast;

    // State, round-robin history and per-source packet counters.
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_r <= IDLE;
            last_r  <= SRC_INJ;
            cnt0_r  <= '0;
            cnt1_r  <= '0;
        end else begin
            state_r <= state_s;
            if (eop_s && (state_r == GRANT0)) begin
                last_r <= SRC_PIO;
                cnt0_r <= cnt0_r + CNT_ONE;
            end else if (eop_s && (state_r == GRANT1)) begin
                last_r <= SRC_INJ;
                cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
                last_r <= last_r;
            end
        end
    end

    assign s0_ack   = (state_r == GRANT0);
    assign grant_id = grant_id_of(state_r);
    assign pkt_cnt0 = cnt0_r;
    assign pkt_cnt1 = cnt1_r;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Randomized self-checking bench for pcie_tx_arbiter: queue-driven sources,
// a per-cycle monitor checking arbitration rules and payload, and scenario tasks.
module tb_pcie_tx_arbiter;

    localparam int CW = 12;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [3:0]  u;
        logic        l;
    } beat_t;

    logic          pcie_clk = 1'b0;
    logic          pcie_rst;
    logic          s0_req, s0_ack, s0_tvalid, s0_tlast, s0_tready;
    logic [63:0]   s0_tdata;
    logic [7:0]    s0_tkeep;
    logic [3:0]    s0_tuser;
    logic          s1_tvalid, s1_tlast, s1_tready;
    logic [63:0]   s1_tdata;
    logic [7:0]    s1_tkeep;
    logic [3:0]    s1_tuser;
    logic          m_tvalid, m_tlast, m_tready;
    logic [63:0]   m_tdata;
    logic [7:0]    m_tkeep;
    logic [3:0]    m_tuser;
    logic [1:0]    grant_id;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;

    int tests_run    = 0;
    int tests_failed = 0;

    beat_t q0[$], q1[$], e0[$], e1[$];
    int    pkt_order[$];
    bit    rand_rdy = 1'b0;
    int    model_last = 2;
    int    m_cnt0 = 0, m_cnt1 = 0;
    int    beat_idx = 0;
    int    total_beats = 0;

    pcie_tx_arbiter #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8), .CNT_WIDTH(CW)) dut (
        .pcie_clk(pcie_clk), .pcie_rst(pcie_rst),
        .s0_req(s0_req), .s0_ack(s0_ack), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast),
        .s0_tready(s0_tready), .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
        .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser),
        .grant_id(grant_id), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic enqueue(input int src, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            beat_t b;
            b.d = {$urandom, $urandom};
            b.k = 8'($urandom);
            b.u = 4'($urandom);
            b.l = (i == nbeats - 1);
            if (src == 0) begin
                q0.push_back(b);
                e0.push_back(b);
            end else begin
                q1.push_back(b);
                e1.push_back(b);
            end
        end
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge pcie_clk);
            #1;
            if (e0.size() == 0 && e1.size() == 0 && q0.size() == 0 &&
                q1.size() == 0 && grant_id == 2'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Source and sink drivers: present the queue heads, pop on observed handshakes.
    initial begin
        bit f0, f1;
        s0_req = 1'b0; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s0_tdata = 64'd0; s0_tkeep = 8'd0; s0_tuser = 4'd0;
        s1_tvalid = 1'b0; s1_tlast = 1'b0;
        s1_tdata = 64'd0; s1_tkeep = 8'd0; s1_tuser = 4'd0;
        m_tready = 1'b1;
        forever begin
            @(negedge pcie_clk);
            f0 = s0_tvalid && s0_tready;
            f1 = s1_tvalid && s1_tready;
            @(posedge pcie_clk);
            #1;
            if (f0 && q0.size() > 0) void'(q0.pop_front());
            if (f1 && q1.size() > 0) void'(q1.pop_front());
            s0_req    = (q0.size() > 0);
            s0_tvalid = (q0.size() > 0);
            if (q0.size() > 0) {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = q0[0];
            else {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = 77'd0;
            s1_tvalid = (q1.size() > 0);
            if (q1.size() > 0) {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = q1[0];
            else {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = 77'd0;
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: arbitration rules, one-cycle gaps, payload order and counters.
    initial begin
        bit    have_exp = 1'b0, prev_last = 1'b0, in_pkt = 1'b0;
        int    exp_gid = 0, pkt_src = 0;
        beat_t o;
        forever begin
            @(negedge pcie_clk);
            if (pcie_rst) begin
                model_last = 2; m_cnt0 = 0; m_cnt1 = 0;
                have_exp = 1'b0; prev_last = 1'b0; in_pkt = 1'b0; beat_idx = 0;
                tests_run++;
                if (grant_id !== 2'd0 || m_tvalid !== 1'b0 || pkt_cnt0 !== 0 ||
                    pkt_cnt1 !== 0 || s0_ack !== 1'b0 || s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL reset_state: gid=%0d tvalid=%0b cnt0=%0h cnt1=%0h ack=%0b rdy=%0b%0b, required all 0",
                             grant_id, m_tvalid, pkt_cnt0, pkt_cnt1, s0_ack, s0_tready, s1_tready);
                end
            end else begin
                if (have_exp) begin
                    tests_run++;
                    if (grant_id !== 2'(exp_gid)) begin
                        tests_failed++;
                        $display("FAIL arbitration: grant_id=%0d required %0d", grant_id, exp_gid);
                    end
                end
                if (prev_last) begin
                    tests_run++;
                    if (grant_id !== 2'd0) begin
                        tests_failed++;
                        $display("FAIL gap_after_tlast: grant_id=%0d required 0", grant_id);
                    end
                end
                tests_run++;
                if (pkt_cnt0 !== m_cnt0[CW-1:0] || pkt_cnt1 !== m_cnt1[CW-1:0]) begin
                    tests_failed++;
                    $display("FAIL pkt_counters: cnt0=%0h cnt1=%0h required %0h %0h",
                             pkt_cnt0, pkt_cnt1, m_cnt0[CW-1:0], m_cnt1[CW-1:0]);
                end
            end
            have_exp  = 1'b0;
            prev_last = 1'b0;
            o = {m_tdata, m_tkeep, m_tuser, m_tlast};
            if (grant_id == 2'd0) begin
                tests_run++;
                if (o !== 77'd0 || m_tvalid !== 1'b0 || s0_tready !== 1'b0 ||
                    s1_tready !== 1'b0 || s0_ack !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL idle_outputs: m=%0h tvalid=%0b rdy=%0b%0b ack=%0b, required all 0",
                             o, m_tvalid, s0_tready, s1_tready, s0_ack);
                end
                if (s0_req && s1_tvalid) exp_gid = (model_last == 1) ? 2 : 1;
                else if (s0_req)         exp_gid = 1;
                else if (s1_tvalid)      exp_gid = 2;
                else                     exp_gid = 0;
                have_exp = 1'b1;
            end else if (grant_id == 2'd1 || grant_id == 2'd2) begin
                tests_run++;
                if (s0_ack !== (grant_id == 2'd1) ||
                    (grant_id == 2'd1 && (s1_tready !== 1'b0 || s0_tready !== m_tready)) ||
                    (grant_id == 2'd2 && (s0_tready !== 1'b0 || s1_tready !== m_tready))) begin
                    tests_failed++;
                    $display("FAIL grant_handshake: gid=%0d ack=%0b rdy0=%0b rdy1=%0b m_tready=%0b",
                             grant_id, s0_ack, s0_tready, s1_tready, m_tready);
                end
                if (m_tvalid) begin
                    tests_run++;
                    if ((grant_id == 2'd1 && (e0.size() == 0 || o !== e0[0])) ||
                        (grant_id == 2'd2 && (e1.size() == 0 || o !== e1[0]))) begin
                        tests_failed++;
                        $display("FAIL beat_payload: src=%0d got %0h required %0h", grant_id, o,
                                 (grant_id == 2'd1) ? ((e0.size() > 0) ? e0[0] : 77'd0)
                                                    : ((e1.size() > 0) ? e1[0] : 77'd0));
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (grant_id == 2'd1 && e0.size() > 0) void'(e0.pop_front());
                    if (grant_id == 2'd2 && e1.size() > 0) void'(e1.pop_front());
                    total_beats++;
                    if (!in_pkt) begin
                        in_pkt  = 1'b1;
                        pkt_src = int'(grant_id);
                        pkt_order.push_back(pkt_src);
                        beat_idx = 0;
                    end else begin
                        tests_run++;
                        if (int'(grant_id) != pkt_src) begin
                            tests_failed++;
                            $display("FAIL interleave: gid=%0d mid-packet of src %0d", grant_id, pkt_src);
                        end
                    end
                    beat_idx++;
                    if (m_tlast) begin
                        in_pkt     = 1'b0;
                        prev_last  = 1'b1;
                        model_last = pkt_src;
                        if (pkt_src == 1) m_cnt0 = (m_cnt0 + 1) % (1 << CW);
                        else              m_cnt1 = (m_cnt1 + 1) % (1 << CW);
                    end
                end
            end else begin
                tests_run++;
                tests_failed++;
                $display("FAIL grant_id_range: got %0d required 0..2", grant_id);
            end
        end
    end

    task automatic test_reset();
        pcie_rst = 1'b1;
        repeat (3) begin @(negedge pcie_clk); #1; end
        pcie_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge pcie_clk); #1;
            tests_run++;
            if (m_tvalid !== 1'b0 || grant_id !== 2'd0 || pkt_cnt0 !== 0 || pkt_cnt1 !== 0) begin
                tests_failed++;
                $display("FAIL idle_after_reset: tvalid=%0b gid=%0d cnt=%0h/%0h required 0",
                         m_tvalid, grant_id, pkt_cnt0, pkt_cnt1);
            end
        end
    endtask

    task automatic test_single_tlp();
        bit ok;
        int b0 = total_beats;
        enqueue(0, 3);
        @(negedge pcie_clk); #1;
        tests_run++;
        if (s0_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_latency_early: s0_ack=%0b required 0", s0_ack);
        end
        @(negedge pcie_clk); #1;
        tests_run++;
        if (s0_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL ack_latency: s0_ack=%0b required 1", s0_ack);
        end
        wait_idle(50, ok);
        tests_run++;
        if (!ok || pkt_cnt0 !== 12'd1 || total_beats - b0 != 3) begin
            tests_failed++;
            $display("FAIL single_tlp: done=%0b cnt0=%0h beats=%0d required 1/1/3",
                     ok, pkt_cnt0, total_beats - b0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int first = (model_last == 1) ? 2 : 1;
        pkt_order.delete();
        for (int i = 0; i < 4; i++) begin
            enqueue(0, 2);
            enqueue(1, 2);
        end
        wait_idle(200, ok);
        tests_run++;
        if (!ok || pkt_order.size() != 8 || pkt_cnt0 !== 12'd5 || pkt_cnt1 !== 12'd4) begin
            tests_failed++;
            $display("FAIL alternate_counts: done=%0b pkts=%0d cnt0=%0h cnt1=%0h required 1/8/5/4",
                     ok, pkt_order.size(), pkt_cnt0, pkt_cnt1);
        end
        for (int i = 0; i < pkt_order.size(); i++) begin
            int want = (i % 2 == 0) ? first : 3 - first;
            tests_run++;
            if (pkt_order[i] != want) begin
                tests_failed++;
                $display("FAIL alternate_order[%0d]: src=%0d required %0d", i, pkt_order[i], want);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok, seen = 1'b0;
        pkt_order.delete();
        rand_rdy = 1'b1;
        enqueue(1, 5);
        for (int i = 0; i < 20; i++) begin
            @(negedge pcie_clk); #1;
            if (grant_id == 2'd2) begin seen = 1'b1; break; end
        end
        enqueue(0, 2);
        wait_idle(300, ok);
        rand_rdy = 1'b0;
        tests_run++;
        if (!seen || !ok || pkt_order.size() != 2 || pkt_cnt1 !== 12'd5 || pkt_cnt0 !== 12'd6) begin
            tests_failed++;
            $display("FAIL backpressure: grant=%0b done=%0b pkts=%0d cnt0=%0h cnt1=%0h required 1/1/2/6/5",
                     seen, ok, pkt_order.size(), pkt_cnt0, pkt_cnt1);
        end else begin
            tests_run++;
            if (pkt_order[0] != 2 || pkt_order[1] != 1) begin
                tests_failed++;
                $display("FAIL backpressure_order: %0d,%0d required 2,1", pkt_order[0], pkt_order[1]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok, hit = 1'b0;
        enqueue(1, 4);
        for (int i = 0; i < 30; i++) begin
            @(negedge pcie_clk); #1;
            if (grant_id == 2'd2 && beat_idx == 1) begin hit = 1'b1; break; end
        end
        pcie_rst = 1'b1;
        q1.delete();
        e1.delete();
        @(negedge pcie_clk); #1;
        tests_run++;
        if (!hit || grant_id !== 2'd0 || m_tvalid !== 1'b0 || pkt_cnt0 !== 0 || pkt_cnt1 !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_packet: hit=%0b gid=%0d tvalid=%0b cnt=%0h/%0h required 1/0/0/0/0",
                     hit, grant_id, m_tvalid, pkt_cnt0, pkt_cnt1);
        end
        pcie_rst = 1'b0;
        pkt_order.delete();
        enqueue(1, 2);
        enqueue(0, 2);
        wait_idle(100, ok);
        tests_run++;
        if (!ok || pkt_order.size() != 2 || pkt_order[0] != 1 || pkt_cnt0 !== 12'd1 || pkt_cnt1 !== 12'd1) begin
            tests_failed++;
            $display("FAIL first_tie_after_reset: done=%0b pkts=%0d first=%0d cnt=%0h/%0h required 1/2/1/1/1",
                     ok, pkt_order.size(), (pkt_order.size() > 0) ? pkt_order[0] : 0, pkt_cnt0, pkt_cnt1);
        end
    endtask

    task automatic test_counter_wrap();
        bit ok;
        int n = (1 << CW) - 1 - m_cnt1;
        for (int i = 0; i < n; i++) enqueue(1, 1);
        wait_idle(2 * n + 100, ok);
        tests_run++;
        if (!ok || pkt_cnt1 !== 12'hFFF) begin
            tests_failed++;
            $display("FAIL counter_preload: done=%0b cnt1=%0h required fff", ok, pkt_cnt1);
        end
        enqueue(1, 1);
        wait_idle(50, ok);
        tests_run++;
        if (!ok || pkt_cnt1 !== 12'h000 || pkt_cnt0 !== 12'd1) begin
            tests_failed++;
            $display("FAIL counter_wrap: done=%0b cnt1=%0h cnt0=%0h required 000/1", ok, pkt_cnt1, pkt_cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_single_tlp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pcie_tx_arbiter.md
# pcie_tx_arbiter

Packet-level arbiter that shares the single PCIe core transmit AXI4-Stream port between two TLP sources: the PIO completion engine (req/ack + AXIS) and the Ethernet-to-PCIe injection path (plain AXIS). Sits in the `pcie_clk` domain between both sources and the 7-series PCIe core `s_axis_tx` input. Grants whole TLPs round-robin, holding a grant until the `tlast` beat is accepted, so TLPs from the two sources never interleave.

## Interface
- `C_DATA_WIDTH`, 64, AXIS data width.
- `KEEP_WIDTH`, `C_DATA_WIDTH/8`, tkeep width.
- `CNT_WIDTH`, 16, width of the per-source packet counters.

- `pcie_clk`  in  1  sole clock; user clock of the PCIe core.
- `pcie_rst`  in  1  reset, synchronous, active-high.
- `s0_req`  in  1  PIO source requests the TX port; held until its packet completes.
- `s0_ack`  out  1  PIO source owns the port; level, high for the whole grant.
- `s0_tvalid`, `s0_tlast`  in  1 each  PIO AXIS beat qualifiers.
- `s0_tready`  out  1  PIO AXIS ready.
- `s0_tdata`  in  `C_DATA_WIDTH`  PIO data.
- `s0_tkeep`  in  `KEEP_WIDTH`  PIO byte enables.
- `s0_tuser`  in  4  PIO tuser, passed through.
- `s1_tvalid`, `s1_tlast`  in  1 each  inject AXIS; `s1_tvalid` is also its request.
- `s1_tready`  out  1  inject AXIS ready.
- `s1_tdata`, `s1_tkeep`, `s1_tuser`  in  `C_DATA_WIDTH` / `KEEP_WIDTH` / 4  inject payload.
- `m_tvalid`, `m_tlast`  out  1 each  to the PCIe core.
- `m_tready`  in  1  from the PCIe core.
- `m_tdata`, `m_tkeep`, `m_tuser`  out  `C_DATA_WIDTH` / `KEEP_WIDTH` / 4  to the PCIe core.
- `grant_id`  out  2  status: 0 = idle, 1 = source 0, 2 = source 1.
- `pkt_cnt0`, `pkt_cnt1`  out  `CNT_WIDTH`  TLPs forwarded per source; wrap at 2^`CNT_WIDTH`.

## Operation
- FSM states `IDLE`, `GRANT0`, `GRANT1`. Register `last` holds the most recently granted source.
- Requests: `r0 = s0_req`, `r1 = s1_tvalid`.
- `IDLE` transitions:
  - Only `r0` high: go to `GRANT0`.
  - Only `r1` high: go to `GRANT1`.
  - Both high: grant the source that is not `last`.
  - Neither high: stay in `IDLE`.
- `GRANTx` datapath, combinational: `m_tvalid/tlast/tdata/tkeep/tuser` = source x; `sx_tready = m_tready`; the other source's `tready` = 0.
- `s0_ack = (state == GRANT0)`.
- End of packet: an `m_tvalid & m_tready & m_tlast` beat returns the FSM to `IDLE`, sets `last` = x, and increments `pkt_cntx`.
- Requests are ignored during a grant. Deassertion of `s0_req` or `s1_tvalid` mid-packet neither ends nor changes the grant; only `tlast` acceptance ends it.
- Outside the grant states: all `m_*` outputs are 0 and both `tready` outputs are 0.
- Counter width rule: `pkt_cntx` is a `CNT_WIDTH`-bit unsigned counter that wraps silently, for example `0xFFFF` → `0x0000`.

## Timing
- Reset values (next edge with `pcie_rst` high):
  - state `IDLE`, `last` = 1, so source 0 wins the first tie.
  - `pkt_cnt0` = `pkt_cnt1` = 0, `grant_id` = 0, `s0_ack` = 0.
  - `m_tvalid` = 0, `s0_tready` = `s1_tready` = 0.
- Reset mid-packet aborts the grant; the partial TLP is not completed, and the core reset accompanies `pcie_rst`.
- Grant latency: a request sampled high in `IDLE` at edge N puts the FSM in `GRANTx` after edge N. The first beat can transfer in cycle N+1.
- Datapath latency: zero cycles; no registers in the data path.
- Inter-packet gap: exactly one `IDLE` cycle after each `tlast` beat, including back-to-back packets from the same source.
- Single-beat packet: `tvalid & tlast & tready` in the first grant cycle → `IDLE` on the next cycle.
- `m_tready` low holds the beat. AXIS rule: the granted source keeps its data stable while `tvalid & !tready`.
- Simultaneous new request and `tlast` completion: the new request is evaluated in the following `IDLE` cycle.

## Structure
- Shared package `pcie_tx_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} arb_state_t`
  - constants `SRC_PIO = 1'b0` and `SRC_INJ = 1'b1`
  - `grant_id` encodings.
- No sub-module; the FSM, mux and counters fit in one module of roughly 150 lines.

## Test plan
- Reset then idle: `m_tvalid` = 0, `grant_id` = 0, counters = 0 for 20 cycles.
- `s0_req` with a 3-beat TLP, `m_tready` = 1:
  - `s0_ack` rises one cycle after `s0_req`.
  - 3 beats appear on `m_*` unchanged.
  - `pkt_cnt0` = 1, then one `IDLE` cycle.
- Both sources request continuously, 2-beat TLPs: outputs alternate src0, src1, src0, src1. After 8 packets, `pkt_cnt0` = `pkt_cnt1` = 4 and no beats are interleaved.
- Random `m_tready` backpressure (50%) during a 5-beat `s1` TLP with `s0_req` high throughout: all 5 beats arrive in order, `s0_tready` stays 0, and `GRANT0` follows.
- `pcie_rst` asserted on beat 2 of a 4-beat `GRANT1` TLP: the next cycle shows `IDLE`, `m_tvalid` = 0, counters = 0; a following `s0_req` is granted first.
- `pkt_cnt1` preloaded by sending 65535 TLPs, then one more: it reads `0x0000`.
